// File: rtl/inv_det_divider.sv
// Divides the 25 unnormalised inverse entries by the determinant, one entry at a time,
// with a bit-serial restoring divider; results are Q(W-FRAC).FRAC, saturated, streamed out.
module inv_det_divider #(
   parameter int unsigned W    = 20,
   parameter int unsigned FRAC = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [25*W-1:0]   b_flat,
   input  logic [W-1:0]      det,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_idx,
   output logic [W-1:0]      out_q,
   output logic              out_sat,
   output logic              busy,
   output logic              done,
   output logic              dz_err
);

   localparam int unsigned N  = W + FRAC;
   localparam int unsigned CW = $clog2(N + 1);

   localparam logic [N-1:0] MaxPosMag = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [N-1:0] MaxNegMag = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StLoad, StDiv, StOut} state_e;

   state_e state_q, state_d;

   logic [25*W-1:0] b_q;
   logic [W-1:0]    det_q;
   logic [4:0]      idx_q;
   logic [N-1:0]    dvd_q;
   logic [N-1:0]    quo_q;
   logic [W-1:0]    dvs_q;
   logic [W-1:0]    rem_q;
   logic            sign_q;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    q_q;
   logic            sat_q;
   logic            done_q;
   logic            dz_q;

   logic [W-1:0] b_sel, b_abs, det_abs;
   logic [W:0]   rem_sh;
   logic         ge;
   logic [W-1:0] rem_nx;
   logic [N-1:0] quo_nx;
   logic [W-1:0] q_nx;
   logic         sat_nx;
   logic         last_step;

   assign b_sel   = b_q[idx_q*W +: W];
   // |-2^(W-1)| wraps to 2^(W-1), which is correct when read as unsigned
   assign b_abs   = b_sel[W-1] ? (~b_sel + W'(1)) : b_sel;
   assign det_abs = det_q[W-1] ? (~det_q + W'(1)) : det_q;

   assign rem_sh    = {rem_q, dvd_q[N-1]};
   assign ge        = rem_sh >= {1'b0, dvs_q};
   assign rem_nx    = ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
   assign quo_nx    = {quo_q[N-2:0], ge};
   assign last_step = (cnt_q == CW'(N - 1));

   always_comb begin
      sat_nx = 1'b0;
      q_nx   = quo_nx[W-1:0];
      if (!sign_q) begin
         if (quo_nx > MaxPosMag) begin
            sat_nx = 1'b1;
            q_nx   = {1'b0, {(W-1){1'b1}}};
         end
      end else if (quo_nx > MaxNegMag) begin
         sat_nx = 1'b1;
         q_nx   = {1'b1, {(W-1){1'b0}}};
      end else begin
         q_nx = ~quo_nx[W-1:0] + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start && det != '0) state_d = StLoad;
         StLoad:  state_d = StDiv;
         StDiv:   if (last_step) state_d = StOut;
         StOut:   if (out_ready) state_d = (idx_q == 5'd24) ? StIdle : StLoad;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b_q    <= '0;
         det_q  <= '0;
         idx_q  <= '0;
         dvd_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         sign_q <= 1'b0;
         cnt_q  <= '0;
         q_q    <= '0;
         sat_q  <= 1'b0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  if (det == '0) begin
                     dz_q   <= 1'b1;
                     done_q <= 1'b1;
                  end else begin
                     b_q   <= b_flat;
                     det_q <= det;
                     dz_q  <= 1'b0;
                     idx_q <= '0;
                  end
               end
            end
            StLoad: begin
               dvd_q  <= {b_abs, {FRAC{1'b0}}};
               dvs_q  <= det_abs;
               sign_q <= b_sel[W-1] ^ det_q[W-1];
               rem_q  <= '0;
               quo_q  <= '0;
               cnt_q  <= '0;
            end
            StDiv: begin
               dvd_q <= dvd_q << 1;
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + CW'(1);
               if (last_step) begin
                  q_q   <= q_nx;
                  sat_q <= sat_nx;
               end
            end
            StOut: begin
               if (out_ready) begin
                  if (idx_q == 5'd24) done_q <= 1'b1;
                  else                idx_q  <= idx_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state_q == StOut);
   assign out_idx   = idx_q;
   assign out_q     = q_q;
   assign out_sat   = sat_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign dz_err    = dz_q;

endmodule

// File: tb/tb_inv_det_divider.sv
// Randomised bench for inv_det_divider: each streamed quotient is compared against a
// plain-arithmetic division model, plus latency, backpressure, zero-det and reset checks.
module tb_inv_det_divider;

   localparam int W    = 20;
   localparam int FRAC = 10;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [25*W-1:0] b_flat;
   logic [W-1:0]    det;
   logic            out_valid;
   logic            out_ready;
   logic [4:0]      out_idx;
   logic [W-1:0]    out_q;
   logic            out_sat;
   logic            busy;
   logic            done;
   logic            dz_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] got_q   [25];
   logic         got_sat [25];

   always #5 clk = ~clk;

   inv_det_divider #(.W(W), .FRAC(FRAC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .b_flat    (b_flat),
      .det       (det),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_q     (out_q),
      .out_sat   (out_sat),
      .busy      (busy),
      .done      (done),
      .dz_err    (dz_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: truncating signed fixed-point division with clamping
   task automatic model(input logic [W-1:0] b, input logic [W-1:0] d,
                        output logic [W-1:0] q, output logic sat);
      longint bs, ds, bm, dm, qm;
      bit     neg;
      bs  = longint'($signed(b));
      ds  = longint'($signed(d));
      bm  = (bs < 0) ? -bs : bs;
      dm  = (ds < 0) ? -ds : ds;
      qm  = (bm * (64'sd1 << FRAC)) / dm;
      neg = (bs < 0) != (ds < 0);
      sat = 1'b0;
      if (!neg) begin
         if (qm > (64'sd1 << (W-1)) - 1) begin
            sat = 1'b1;
            q   = {1'b0, {(W-1){1'b1}}};
         end else q = W'(qm);
      end else begin
         if (qm > (64'sd1 << (W-1))) begin
            sat = 1'b1;
            q   = {1'b1, {(W-1){1'b0}}};
         end else q = W'(-qm);
      end
   endtask

   function automatic logic [W-1:0] rnd_entry();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = 20'h80000;
         2:       v = 20'h7FFFF;
         3:       v = W'($urandom_range(0, 15));
         4:       v = -W'($urandom_range(1, 15));
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   function automatic logic [W-1:0] rnd_det();
      logic [W-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = 20'h00001;
         1:       v = 20'hFFFFF;
         2:       v = 20'h80000;
         3:       v = W'($urandom_range(1, 300));
         4:       v = -W'($urandom_range(1, 300));
         default: v = W'($urandom);
      endcase
      if (v == '0) v = 20'h00003;
      return v;
   endfunction

   function automatic logic [25*W-1:0] rnd_flat();
      logic [25*W-1:0] f;
      for (int e = 0; e < 25; e++) f[e*W +: W] = rnd_entry();
      return f;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_q"},     out_q,     0);
      check({tag, "_idx"},   out_idx,   0);
      check({tag, "_sat"},   out_sat,   0);
      check({tag, "_busy"},  busy,      0);
      check({tag, "_done"},  done,      0);
      check({tag, "_dz"},    dz_err,    0);
   endtask

   // Runs one job; stall_idx holds out_ready low 10 cycles there, abort_idx resets
   // during cycle 15 of that entry's divide.
   task automatic run_job(input logic [25*W-1:0] bf, input logic [W-1:0] dv,
                          input int stall_idx, input int abort_idx);
      logic [W-1:0] eq, hq;
      logic         es;
      logic [4:0]   hi;
      int           cyc, total;
      b_flat    = bf;
      det       = dv;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      total = 0;
      start = 1'b0;
      check("dz_clear", dz_err, 0);
      check("busy_on", busy, 1);
      b_flat = rnd_flat();
      det    = rnd_det();
      for (int i = 0; i < 25; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
            total++;
         end
         cyc = 1;
         while (!out_valid && cyc < 40) begin
            check("no_done", done, 0);
            if (i == abort_idx && cyc == 16) begin
               rst = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               check_all_zero("abort");
               for (int k = 0; k < 5; k++) begin
                  @(posedge clk); #1;
                  check("abort_no_done", done, 0);
                  check("abort_idle", busy, 0);
               end
               return;
            end
            @(posedge clk); #1;
            cyc++;
            total++;
         end
         check("latency", cyc, 32);
         check("done_vs_valid", done, 0);
         model(bf[i*W +: W], dv, eq, es);
         check("idx", out_idx, i);
         check("q", out_q, eq);
         check("sat", out_sat, es);
         got_q[i]   = out_q;
         got_sat[i] = out_sat;
         if (i == stall_idx) begin
            hq        = out_q;
            hi        = out_idx;
            out_ready = 1'b0;
            for (int s = 0; s < 10; s++) begin
               start  = s[0];
               b_flat = rnd_flat();
               det    = W'($urandom_range(0, 3));
               @(posedge clk); #1;
               total++;
               check("stall_valid", out_valid, 1);
               check("stall_q", out_q, hq);
               check("stall_idx", out_idx, hi);
            end
            start     = 1'b0;
            out_ready = 1'b1;
            check("stall_dz", dz_err, 0);
         end
      end
      @(posedge clk); #1;
      total++;
      check("done", done, 1);
      check("job_cycles", total, (stall_idx >= 0) ? 810 : 800);
      check("end_busy", busy, 0);
      check("end_valid", out_valid, 0);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [25*W-1:0] f;
      rst       = 1'b1;
      start     = 1'b1;
      out_ready = 1'b1;
      b_flat    = '0;
      det       = 20'h00001;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;

      f = '0;
      for (int e = 0; e < 25; e += 6) f[e*W +: W] = 20'h00001;
      run_job(f, 20'h00001, -1, -1);
      check("ident_diag", got_q[12], 20'h00400);
      check("ident_off", got_q[1], 20'h00000);

      f = rnd_flat();
      f[0*W +: W] = 20'hFFFFD;
      f[1*W +: W] = 20'h00007;
      run_job(f, 20'h00002, -1, -1);
      check("neg_frac", got_q[0], 20'hFFA00);
      check("pos_frac", got_q[1], 20'h00E00);

      f = rnd_flat();
      f[0*W +: W] = 20'h7FFFF;
      f[1*W +: W] = 20'h80000;
      run_job(f, 20'h00001, -1, -1);
      check("sat_pos_q", got_q[0], 20'h7FFFF);
      check("sat_pos_f", got_sat[0], 1);
      check("sat_neg_q", got_q[1], 20'h80000);
      check("sat_neg_f", got_sat[1], 1);

      det   = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("dz_set", dz_err, 1);
      check("dz_done", done, 1);
      check("dz_busy", busy, 0);
      check("dz_valid", out_valid, 0);
      @(posedge clk); #1;
      check("dz_done_pulse", done, 0);
      check("dz_sticky", dz_err, 1);
      check("dz_idle", busy, 0);
      run_job(rnd_flat(), 20'h00005, -1, -1);

      run_job(rnd_flat(), rnd_det(), 3, -1);
      run_job(rnd_flat(), rnd_det(), -1, 2);
      run_job(rnd_flat(), rnd_det(), -1, -1);

      for (int j = 0; j < 5; j++) run_job(rnd_flat(), rnd_det(), -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
